// File: rtl/dm_access_unit.sv
// Load/store initiator for a word-only data memory. Sub-word stores are done as read-modify-write;
// sub-word loads are lane-aligned and sign- or zero-extended.
module dm_access_unit #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       pc_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              dm_we,
   output logic [31:0]       dm_pc,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_din,
   input  logic [31:0]       dm_dout
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic              err_q, err_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       word_q, word_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              misaligned;

   // Byte-address bits above the word index are deliberately ignored so the word address wraps.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_W+2];

   function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] sz,
                                              input logic sx, input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = word[{lo[1], 4'b0000} +: 16];
      case (sz)
         SZ_BYTE: return {{24{sx & b[7]}}, b};
         SZ_HALF: return {{16{sx & h[15]}}, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] lo);
      logic [31:0] m;
      m = word;
      case (sz)
         SZ_BYTE: m[{lo, 3'b000} +: 8]    = wd[7:0];
         SZ_HALF: m[{lo[1], 4'b0000} +: 16] = wd[15:0];
         default: m = wd;
      endcase
      return m;
   endfunction

   always_comb begin
      // NOTE: every _d gets its current value first, so no path through the case can infer a latch.
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      sext_d  = sext_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      pc_d    = pc_q;
      word_d  = word_q;
      rdata_d = rdata_q;

      misaligned = (size == 2'b11) || ((size == SZ_HALF) && addr[0]) ||
                   ((size == SZ_WORD) && (addr[1:0] != 2'b00));

      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d    = we;
               size_d  = size;
               sext_d  = sext;
               addr_d  = addr[ADDR_W+1:0];
               wdata_d = wdata;
               pc_d    = pc_in;
               err_d   = misaligned;
               if (misaligned)                      state_d = S_DONE;
               else if (we && (size == SZ_WORD))    state_d = S_WR;
               else                                 state_d = S_RD;
            end
         end
         S_RD: begin
            word_d = dm_dout;
            if (we_q) begin
               state_d = S_WR;
            end else begin
               rdata_d = load_align(dm_dout, size_q, sext_q, addr_q[1:0]);
               state_d = S_DONE;
            end
         end
         S_WR:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         pc_q    <= '0;
         word_q  <= '0;
         rdata_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         pc_q    <= pc_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
      end
   end

   // The write strobe comes from state alone, so it can never glitch on req and drops with reset.
   assign dm_we   = (state_q == S_WR);
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign err     = (state_q == S_DONE) && err_q;
   assign rdata   = rdata_q;
   assign dm_pc   = pc_q;
   assign dm_addr = addr_q[ADDR_W+1:2];
   assign dm_din  = store_merge(word_q, wdata_q, size_q, addr_q[1:0]);

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: a behavioural dm, a shadow-memory reference model and scoreboards for
// completions and memory writes.
module tb_dm_access_unit;

   localparam int ADDR_W = 10;

   logic              clk, reset, req, we, sext;
   logic [1:0]        size;
   logic [31:0]       addr, wdata, pc_in;
   logic              busy, done, err, dm_we;
   logic [31:0]       rdata, dm_pc, dm_din, dm_dout;
   logic [ADDR_W-1:0] dm_addr;

   dm_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
      .addr(addr), .wdata(wdata), .pc_in(pc_in), .busy(busy), .done(done), .err(err),
      .rdata(rdata), .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_din(dm_din),
      .dm_dout(dm_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic err; logic [31:0] rdata; } exp_t;
   typedef struct { logic [31:0] din; logic [ADDR_W-1:0] waddr; logic [31:0] pc; } wr_t;
   typedef struct { logic w; logic [1:0] sz; logic sx; logic [31:0] a; logic [31:0] wd; } op_t;

   logic [31:0] mem     [1 << ADDR_W];
   logic [31:0] ref_mem [1 << ADDR_W];
   logic [31:0] last_rdata;
   logic [31:0] pc_ctr;
   exp_t        sb_q[$];
   wr_t         wr_q[$];
   int          total, bad, we_total;

   assign dm_dout = mem[dm_addr];
   always @(posedge clk) begin
      if (dm_we === 1'b1) begin
         mem[dm_addr] <= dm_din;
         we_total++;
      end
   end

   // Completion scoreboard.
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: got done=1 want no completion");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (err !== e.err) begin
               bad++;
               $display("FAIL done_err: got %b want %b", err, e.err);
            end
            total++;
            if (rdata !== e.rdata) begin
               bad++;
               $display("FAIL done_rdata: got %08h want %08h", rdata, e.rdata);
            end
         end
      end
   end

   // Memory-write scoreboard.
   always @(negedge clk) begin
      if (reset === 1'b1 && dm_we === 1'b1) begin
         total++;
         if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got dm_we=1 addr=%0d din=%08h want no write", dm_addr, dm_din);
         end else begin
            wr_t x;
            x = wr_q.pop_front();
            if (dm_din !== x.din || dm_addr !== x.waddr || dm_pc !== x.pc) begin
               bad++;
               $display("FAIL write: got addr=%0d din=%08h pc=%08h want addr=%0d din=%08h pc=%08h",
                        dm_addr, dm_din, dm_pc, x.waddr, x.din, x.pc);
            end
         end
      end
   end

   // Reference model: updates the shadow memory and queues the expected completion and write.
   task automatic model_access(input op_t op, input logic [31:0] pc, output int lat);
      exp_t              e;
      wr_t               x;
      logic [ADDR_W-1:0] wi;
      logic [31:0]       old, val, mask;
      int                sh;
      wi    = op.a[ADDR_W+1:2];
      old   = ref_mem[wi];
      e.err = 1'b0;
      if (op.sz == 2'b11 || (op.sz == 2'b01 && op.a[0]) || (op.sz == 2'b10 && op.a[1:0] != 2'b00)) begin
         e.err   = 1'b1;
         e.rdata = last_rdata;
         lat     = 1;
      end else if (!op.w) begin
         if (op.sz == 2'b00) begin
            sh  = 8 * op.a[1:0];
            val = (old >> sh) & 32'hFF;
            if (op.sx && val[7]) val = val | 32'hFFFF_FF00;
         end else if (op.sz == 2'b01) begin
            sh  = 16 * op.a[1];
            val = (old >> sh) & 32'hFFFF;
            if (op.sx && val[15]) val = val | 32'hFFFF_0000;
         end else begin
            val = old;
         end
         last_rdata = val;
         e.rdata    = val;
         lat        = 2;
      end else begin
         if (op.sz == 2'b10) begin
            val = op.wd;
            lat = 2;
         end else begin
            sh   = (op.sz == 2'b00) ? 8 * op.a[1:0] : 16 * op.a[1];
            mask = ((op.sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
            val  = (old & ~mask) | ((op.wd << sh) & mask);
            lat  = 3;
         end
         ref_mem[wi] = val;
         x.din   = val;
         x.waddr = wi;
         x.pc    = pc;
         wr_q.push_back(x);
         e.rdata = last_rdata;
      end
      sb_q.push_back(e);
   endtask

   // Drives one request and measures edges to done; hold keeps req high until done is seen.
   task automatic run_op(input op_t op, input bit hold, output int lat, output int exp_lat,
                         output bit busy_ok);
      @(negedge clk);
      pc_ctr = pc_ctr + 32'd4;
      model_access(op, pc_ctr, exp_lat);
      req = 1'b1; we = op.w; size = op.sz; sext = op.sx; addr = op.a; wdata = op.wd; pc_in = pc_ctr;
      lat     = -1;
      busy_ok = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (!hold) req = 1'b0;
         if (done === 1'b1) begin
            lat = c;
            break;
         end
      end
      req = 1'b0;
   endtask

   function automatic op_t mk(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd);
      op_t o;
      o.w = w; o.sz = sz; o.sx = sx; o.a = a; o.wd = wd;
      return o;
   endfunction

   task automatic test_reset();
      #1;
      total++;
      if ({busy, done, err, dm_we} !== 4'b0 || rdata !== 32'h0 || dm_addr !== '0 ||
          dm_din !== 32'h0 || dm_pc !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b we=%b rdata=%08h addr=%0d din=%08h pc=%08h want all zero",
                  busy, done, err, dm_we, rdata, dm_addr, dm_din, dm_pc);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_abort();
      int we_before;
      we_before = we_total;
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h11; wdata = 32'h77; pc_in = 32'h40;
      @(negedge clk);
      req = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_busy_in_rd: got %b want 1", busy);
      end
      reset = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || dm_we !== 1'b0 || done !== 1'b0 || dm_addr !== '0 || dm_din !== 32'h0) begin
         bad++;
         $display("FAIL abort_in_reset: got busy=%b we=%b done=%b addr=%0d din=%08h want all zero",
                  busy, dm_we, done, dm_addr, dm_din);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0 || we_total != we_before) begin
         bad++;
         $display("FAIL abort_after: got busy=%b writes=%0d want busy=0 writes=0", busy, we_total - we_before);
      end
      last_rdata = 32'h0;
   endtask

   task automatic test_word();
      op_t ops[$];
      int  lat, el;
      bit  bok;
      ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF));
      ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
      foreach (ops[i]) begin
         run_op(ops[i], 1'b0, lat, el, bok);
         total++;
         if (lat != el || !bok) begin
            bad++;
            $display("FAIL word[%0d]: got latency=%0d busy_ok=%b want latency=%0d busy_ok=1", i, lat, bok, el);
         end
      end
   endtask

   task automatic test_sub_store();
      op_t ops[$];
      int  lat, el;
      bit  bok;
      ops.push_back(mk(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0055));
      ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
      ops.push_back(mk(1'b1, 2'b01, 1'b0, 32'h26, 32'hAAAA_9876));
      ops.push_back(mk(1'b1, 2'b00, 1'b0, 32'h24, 32'h1234_56C3));
      ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h24, 32'h0));
      foreach (ops[i]) begin
         run_op(ops[i], 1'b0, lat, el, bok);
         total++;
         if (lat != el || !bok) begin
            bad++;
            $display("FAIL sub_store[%0d]: got latency=%0d busy_ok=%b want latency=%0d busy_ok=1", i, lat, bok, el);
         end
      end
   endtask

   task automatic test_sub_load();
      op_t ops[$];
      int  lat, el;
      bit  bok;
      ops.push_back(mk(1'b0, 2'b00, 1'b1, 32'h13, 32'h0));
      ops.push_back(mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0));
      ops.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12, 32'h0));
      ops.push_back(mk(1'b0, 2'b01, 1'b0, 32'h10, 32'h0));
      ops.push_back(mk(1'b0, 2'b00, 1'b1, 32'h11, 32'h0));
      ops.push_back(mk(1'b0, 2'b01, 1'b1, 32'h26, 32'h0));
      ops.push_back(mk(1'b0, 2'b01, 1'b1, 32'h10, 32'h0));
      foreach (ops[i]) begin
         run_op(ops[i], 1'b0, lat, el, bok);
         total++;
         if (lat != el || !bok) begin
            bad++;
            $display("FAIL sub_load[%0d]: got latency=%0d busy_ok=%b want latency=%0d busy_ok=1", i, lat, bok, el);
         end
      end
   endtask

   task automatic test_misaligned();
      op_t ops[$];
      int  lat, el;
      bit  bok;
      int  we_before;
      we_before = we_total;
      ops.push_back(mk(1'b1, 2'b01, 1'b0, 32'h11, 32'h1111_1111));
      ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h12, 32'h0));
      ops.push_back(mk(1'b1, 2'b11, 1'b0, 32'h10, 32'h2222_2222));
      ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h13, 32'h3333_3333));
      foreach (ops[i]) begin
         run_op(ops[i], 1'b0, lat, el, bok);
         total++;
         if (lat != el || !bok) begin
            bad++;
            $display("FAIL misaligned[%0d]: got latency=%0d busy_ok=%b want latency=%0d busy_ok=1", i, lat, bok, el);
         end
      end
      total++;
      if (we_total != we_before) begin
         bad++;
         $display("FAIL misaligned_writes: got %0d want 0", we_total - we_before);
      end
   endtask

   task automatic test_wrap_busy();
      op_t ops[$];
      int  lat, el;
      bit  bok;
      int  we_before;
      we_before = we_total;
      ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D));
      ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0));
      ops.push_back(mk(1'b1, 2'b00, 1'b0, 32'hF000_1FFD, 32'h0000_00A5));
      ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0));
      foreach (ops[i]) begin
         run_op(ops[i], 1'b1, lat, el, bok);
         total++;
         if (lat != el || !bok) begin
            bad++;
            $display("FAIL wrap_busy[%0d]: got latency=%0d busy_ok=%b want latency=%0d busy_ok=1", i, lat, bok, el);
         end
      end
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0 || we_total - we_before != 2) begin
         bad++;
         $display("FAIL wrap_busy_single: got busy=%b writes=%0d want busy=0 writes=2", busy, we_total - we_before);
      end
   endtask

   task automatic test_random();
      int lat, el;
      bit bok;
      for (int i = 0; i < 40; i++) begin
         run_op(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'h20 + 32'($urandom_range(0, 15)), $urandom), 1'b0, lat, el, bok);
         total++;
         if (lat != el || !bok) begin
            bad++;
            $display("FAIL random[%0d]: got latency=%0d busy_ok=%b want latency=%0d busy_ok=1", i, lat, bok, el);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test want end before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         mem[i]     = 32'h0;
         ref_mem[i] = 32'h0;
      end
      total = 0; bad = 0; we_total = 0;
      last_rdata = 32'h0; pc_ctr = 32'h0000_1000;
      reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
      addr = 32'h0; wdata = 32'h0; pc_in = 32'h0;

      test_reset();
      test_abort();
      test_word();
      test_sub_store();
      test_sub_load();
      test_misaligned();
      test_wrap_busy();
      test_random();

      repeat (3) @(negedge clk);
      total++;
      if (sb_q.size() != 0 || wr_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got pending completions=%0d writes=%0d want 0 0", sb_q.size(), wr_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
